// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - pre-add operand alignment stage of the single-precision FP adder
module fp_align_stage #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+FRAC_W:0]  a,
  input  logic [EXP_W+FRAC_W:0]  b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FRAC_W:0]        mant_big,
  output logic [FRAC_W:0]        mant_small,
  output logic [EXP_W-1:0]       exp_out,
  output logic                   sign_big,
  output logic                   sign_small,
  output logic                   guard_out,
  output logic                   sticky_out,
  output logic                   swapped
);

  localparam int M     = FRAC_W + 1;
  localparam int S     = FRAC_W + 2;
  localparam int W     = EXP_W + FRAC_W + 1;
  localparam int CNT_W = $clog2(S + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [CNT_W-1:0] cnt;

  // Operand decode of the captured pair; exponent 0 behaves like exponent 1 with no hidden bit
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [EXP_W-1:0] eff_a;
  logic [EXP_W-1:0] eff_b;
  logic [M-1:0]     sig_a;
  logic [M-1:0]     sig_b;
  logic             b_big;
  logic [EXP_W-1:0] diff;
  logic [31:0]      diff32;
  logic [CNT_W-1:0] cnt_init;

  // Decode, magnitude compare and capped shift count for the COMPARE cycle
  always_comb begin
    exp_a    = a_q[W-2:FRAC_W];
    exp_b    = b_q[W-2:FRAC_W];
    eff_a    = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b    = (exp_b == '0) ? EXP_W'(1) : exp_b;
    sig_a    = {(exp_a != '0), a_q[FRAC_W-1:0]};
    sig_b    = {(exp_b != '0), b_q[FRAC_W-1:0]};
    // strict greater-than keeps A as the big operand on an exact tie
    b_big    = {eff_b, sig_b} > {eff_a, sig_a};
    diff     = b_big ? (eff_b - eff_a) : (eff_a - eff_b);
    diff32   = 32'(diff);
    // beyond S shifts every significand bit has already reached sticky
    cnt_init = (diff32 > 32'(S)) ? CNT_W'(S) : CNT_W'(diff32);
  end

  // Control FSM with registered handshake and datapath outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      exp_out    <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      guard_out  <= 1'b0;
      sticky_out <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready gates capture so the cycle right after reset cannot accept
          if (in_ready && in_valid) begin
            a_q      <= a;
            b_q      <= b;
            in_ready <= 1'b0;
            state    <= COMPARE;
          end else begin
            in_ready <= 1'b1;
          end
        end
        COMPARE: begin
          swapped    <= b_big;
          guard_out  <= 1'b0;
          sticky_out <= 1'b0;
          cnt        <= cnt_init;
          if (b_big) begin
            mant_big   <= sig_b;
            mant_small <= sig_a;
            exp_out    <= eff_b;
            sign_big   <= b_q[W-1];
            sign_small <= a_q[W-1];
          end else begin
            mant_big   <= sig_a;
            mant_small <= sig_b;
            exp_out    <= eff_a;
            sign_big   <= a_q[W-1];
            sign_small <= b_q[W-1];
          end
          if (cnt_init == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // one bit per clock: the old guard folds into sticky, the LSB becomes guard
          sticky_out <= sticky_out | guard_out;
          guard_out  <= mant_small[0];
          mant_small <= mant_small >> 1;
          cnt        <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // results stay frozen until downstream takes them; new operands wait
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - scoreboard bench for fp_align_stage
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant_big;
  logic [23:0] mant_small;
  logic [7:0]  exp_out;
  logic        sign_big;
  logic        sign_small;
  logic        guard_out;
  logic        sticky_out;
  logic        swapped;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [23:0] mb;
    logic [23:0] ms;
    logic [7:0]  e;
    logic        sb;
    logic        ss;
    logic        g;
    logic        st;
    logic        sw;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  fp_align_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .exp_out    (exp_out),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .guard_out  (guard_out),
    .sticky_out (sticky_out),
    .swapped    (swapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic exp_t mk(input logic [23:0] mb, input logic [23:0] ms, input logic [7:0] e,
                              input logic sb, input logic ss, input logic g, input logic st,
                              input logic sw, input int lat);
    exp_t r;
    r.mb = mb; r.ms = ms; r.e = e; r.sb = sb; r.ss = ss;
    r.g = g; r.st = st; r.sw = sw; r.lat = lat;
    return r;
  endfunction

  // Reference: the whole shift done at once on a zero-extended significand
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [7:0]  ex, ey;
    logic [23:0] sx, sy, small_sig;
    logic [49:0] ext;
    logic        yb;
    int          d, c;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    sx = {(x[30:23] != 8'd0), x[22:0]};
    sy = {(y[30:23] != 8'd0), y[22:0]};
    yb = (ey > ex) || ((ey == ex) && (sy > sx));
    d  = yb ? (int'(ey) - int'(ex)) : (int'(ex) - int'(ey));
    c  = (d > 25) ? 25 : d;
    small_sig = yb ? sx : sy;
    ext  = {small_sig, 26'd0} >> c;
    r.mb = yb ? sy : sx;
    r.ms = ext[49:26];
    r.g  = ext[25];
    r.st = |ext[24:0];
    r.e  = yb ? ey : ex;
    r.sb = yb ? y[31] : x[31];
    r.ss = yb ? x[31] : y[31];
    r.sw = yb;
    r.lat = 2 + c;
    return r;
  endfunction

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input exp_t e);
    int waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_mant_big"}, {8'd0, mant_big}, {8'd0, e.mb});
      check({tag, "_mant_small"}, {8'd0, mant_small}, {8'd0, e.ms});
      check({tag, "_exp"}, {24'd0, exp_out}, {24'd0, e.e});
      check({tag, "_signs"}, {30'd0, sign_big, sign_small}, {30'd0, e.sb, e.ss});
      check({tag, "_guard"}, {31'd0, guard_out}, {31'd0, e.g});
      check({tag, "_sticky"}, {31'd0, sticky_out}, {31'd0, e.st});
      check({tag, "_swapped"}, {31'd0, swapped}, {31'd0, e.sw});
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_fall"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ir_rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic [7:0]  rexp;
    exp_t e1, e2a, e2b, e3, e4;
    e1  = mk(24'h800000, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    e2a = mk(24'hC00000, 24'h400000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    e2b = mk(24'hC00000, 24'h800000, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    e3  = mk(24'hA00000, 24'h019999, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9);
    e4  = mk(24'h800000, 24'h000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 27);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {mant_big, exp_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    drive_op(32'h3F800000, 32'h3F800000, e1);  collect("equal");  release_out("equal");
    drive_op(32'h3F800000, 32'h40400000, e2a); collect("one_three"); release_out("one_three");
    drive_op(32'h3F800000, 32'hBFC00000, e2b); collect("exp_tie"); release_out("exp_tie");
    drive_op(32'h41200000, 32'h3DCCCCCD, e3);  collect("ten_tenth"); release_out("ten_tenth");
    drive_op(32'h3F800000, 32'h00000001, e4);  collect("denorm_cap"); release_out("denorm_cap");

    // backpressure: new operands offered while results are held
    drive_op(32'h3F800000, 32'h3F800000, e1);
    collect("bp");
    a = 32'h41200000; b = 32'h3DCCCCCD; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ov", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ir", {31'd0, in_ready}, 32'd0);
      check("bp_hold_mant", {mant_big, 8'd0}, {24'h800000, 8'd0});
      check("bp_hold_small", {8'd0, mant_small}, 32'h00800000);
    end
    release_out("bp");
    drive_op(32'h41200000, 32'h3DCCCCCD, e3);
    collect("bp_next");
    release_out("bp_next");

    // reset in the middle of a long shift
    drive_op(32'h3F800000, 32'h00000001, e4);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("midrst_ov", {31'd0, out_valid}, 32'd0);
    check("midrst_ir", {31'd0, in_ready}, 32'd0);
    check("midrst_mant", {mant_big, exp_out}, 32'd0);
    check("midrst_small", {8'd0, mant_small}, 32'd0);
    check("midrst_flags", {27'd0, sign_big, sign_small, guard_out, sticky_out, swapped}, 32'd0);
    @(posedge clk); #1;
    check("midrst_ir_rise", {31'd0, in_ready}, 32'd1);
    drive_op(32'h41200000, 32'h3DCCCCCD, e3); collect("rerun"); release_out("rerun");

    // random pairs with nearby exponents
    for (int i = 0; i < 8; i++) begin
      rx   = $urandom;
      rexp = rx[30:23] + 8'($urandom_range(0, 30));
      ry   = {1'($urandom_range(0, 1)), rexp, 23'($urandom)};
      if (i[0]) drive_op(rx, ry, model(rx, ry));
      else      drive_op(ry, rx, model(ry, rx));
      collect("rand");
      release_out("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Pre-add alignment stage of the single-precision FP adder datapath.
- Accepts two IEEE-754 operands and selects the larger-magnitude operand ("big").
- Right-shifts the smaller operand's significand ("small") by the exponent difference, one bit per clock.
- Presents both 24-bit significands, aligned, to the downstream 24-bit ripple mantissa adder, with guard/sticky bits for the rounding stage.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; significand width M = FRAC_W+1; maximum shift count S = FRAC_W+2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept an operand pair.
- a  in  EXP_W+FRAC_W+1  operand A, IEEE layout {sign, exp, frac}.
- b  in  EXP_W+FRAC_W+1  operand B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- mant_big  out  M  significand of larger-magnitude operand, hidden bit included.
- mant_small  out  M  aligned (shifted) significand of the smaller operand.
- exp_out  out  EXP_W  effective exponent of the big operand.
- sign_big  out  1  sign of the big operand.
- sign_small  out  1  sign of the small operand.
- guard_out  out  1  last bit shifted out of mant_small.
- sticky_out  out  1  OR of all bits shifted out before the guard bit.
- swapped  out  1  1 when B is the big operand.

Behaviour:
- Reset (rst=1 at an edge): state<=IDLE; all outputs 0, including in_ready and out_valid; any in-flight operation is discarded. in_ready rises in the first cycle after rst deasserts.
- Operand decode:
  - hidden = (exp!=0); eff_exp = (exp==0) ? 1 : exp; sig = {hidden, frac}.
  - Inf/NaN get no special handling; they pass through as ordinary values, and downstream flags them.
- FSM states: IDLE, COMPARE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid, capture a and b, then go to COMPARE.
  - in_ready is 0 in all other states.
- COMPARE (1 cycle):
  - big = operand with larger {eff_exp, sig}; on an exact tie A is big (swapped=0).
  - Load mant_big, exp_out, sign_big, sign_small, swapped; load mant_small = small sig; clear guard and sticky.
  - cnt = min(eff_exp_big - eff_exp_small, S).
  - If cnt==0, go to DONE; else go to SHIFT.
- SHIFT (cnt cycles), each cycle:
  - sticky <= sticky | guard; guard <= mant_small[0]; mant_small <= mant_small>>1; cnt <= cnt-1.
  - Go to DONE on the cycle cnt transitions 1->0.
  - The cap at S is exact: any larger difference yields mant_small=0, guard=0, sticky=OR(all sig bits).
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid falls the next cycle.
  - in_valid is ignored in DONE.
- Latency:
  - Accept edge k, then out_valid=1 from cycle k+2+cnt.
  - Throughput: one operation per 3+cnt cycles minimum.
- Output registers are updated only in COMPARE and SHIFT; they hold their last values in IDLE.
- rst has priority over every transition, including a DONE handshake in the same cycle.

Test Plan:
1. a=0x3F800000, b=0x3F800000 (equal) -> out_valid 2 cycles after accept; mant_big=mant_small=0x800000, exp_out=0x7F, guard=0, sticky=0, swapped=0.
2. a=0x3F800000 (1.0), b=0x40400000 (3.0) -> swapped=1, exp_out=0x80, mant_big=0xC00000, mant_small=0x400000, guard=0, sticky=0, latency 3. Then a=0x3F800000, b=0xBFC00000 (tie on exponent) -> swapped=1, sign_big=1, mant_big=0xC00000, mant_small=0x800000, latency 2.
3. a=0x41200000 (10.0), b=0x3DCCCCCD (0.1) -> diff 7; mant_big=0xA00000, mant_small=0x019999, exp_out=0x82, guard=1, sticky=1, latency 9.
4. a=0x3F800000, b=0x00000001 (denormal) -> cnt capped at 25; mant_small=0x000000, guard=0, sticky=1, latency 27.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, no capture. Raise out_ready -> IDLE next cycle, then new pair accepted.
6. Assert rst for 1 cycle mid-SHIFT of scenario 4 -> next cycle out_valid=0, all outputs 0, in_ready=1 the cycle after. Scenario 3 rerun afterwards gives identical results.
